// File: rtl/bldc_pkg.sv
// Shared types and helpers for the BLDC mode sequencer.
// States, requests, UI codes and hall sequence lookup.
package bldc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEAD     = 3'd1,
    RUN      = 3'd2,
    BRAKE    = 3'd3,
    REVBRAKE = 3'd4,
    FAULT    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_CW,
    REQ_CCW,
    REQ_BRAKE
  } req_e;

  localparam logic [2:0] UI_OFF = 3'b000;
  localparam logic [2:0] UI_CW  = 3'b100;
  localparam logic [2:0] UI_CCW = 3'b010;
  localparam logic [2:0] UI_BRK = 3'b001;

  // 0 marks an invalid hall pattern (000/111)
  function automatic logic [2:0] hall_idx(input logic [2:0] h);
    case (h)
      3'b100:  return 3'd1;
      3'b110:  return 3'd2;
      3'b010:  return 3'd3;
      3'b011:  return 3'd4;
      3'b001:  return 3'd5;
      3'b101:  return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] idx_inc(input logic [2:0] i);
    return (i == 3'd6) ? 3'd1 : i + 3'd1;
  endfunction

  function automatic logic [2:0] idx_dec(input logic [2:0] i);
    return (i == 3'd1) ? 3'd6 : i - 3'd1;
  endfunction

endpackage

// File: rtl/bldc_mode_sequencer_hall.sv
// Hall sensor front end: sync, filter, edge/direction,
// standstill detection and hall fault flagging.
module bldc_hall_monitor
  import bldc_pkg::*;
#(
  parameter int unsigned STOP_CYCLES = 64,
  parameter int unsigned HALL_FILT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hs_i,
  output logic [2:0] hall_f_o,
  output logic       hall_valid_o,
  output logic       hall_fault_o,
  output logic       stopped_o,
  output logic       motion_dir_o
);

  localparam int FW = $clog2(HALL_FILT + 1);
  localparam int SW = $clog2(STOP_CYCLES + 1);

  logic [2:0]    hs_s1_q, hs_s2_q;
  logic [2:0]    cand_q, cand_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [2:0]    hall_q, hall_d;
  logic          valid_q, valid_d;
  logic          jump_q, jump_d;
  logic          dir_q, dir_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          stopped_q, stopped_d;

  logic       accept, up, dn, hedge, both_ok;
  logic [2:0] old_i, new_i;

  always_comb begin
    cand_d = hs_s2_q;
    if (hs_s2_q != cand_q)
      fcnt_d = FW'(1);
    else if (fcnt_q == FW'(HALL_FILT))
      fcnt_d = fcnt_q;
    else
      fcnt_d = fcnt_q + 1'b1;
    accept = (fcnt_d == FW'(HALL_FILT)) &&
             (!valid_q || hs_s2_q != hall_q);
    old_i   = hall_idx(hall_q);
    new_i   = hall_idx(hs_s2_q);
    both_ok = accept && valid_q &&
              old_i != 3'd0 && new_i != 3'd0;
    up      = both_ok && new_i == idx_inc(old_i);
    dn      = both_ok && new_i == idx_dec(old_i);
    // invalid codes are caught by the level check instead
    jump_d  = both_ok && !up && !dn;
    hedge   = up || dn;
    hall_d  = accept ? hs_s2_q : hall_q;
    valid_d = valid_q || accept;
    dir_d   = up ? 1'b1 : (dn ? 1'b0 : dir_q);
    if (hedge)
      scnt_d = '0;
    else if (scnt_q == SW'(STOP_CYCLES))
      scnt_d = scnt_q;
    else
      scnt_d = scnt_q + 1'b1;
    stopped_d = !hedge &&
                (stopped_q || scnt_d == SW'(STOP_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_s1_q   <= '0;
      hs_s2_q   <= '0;
      cand_q    <= '0;
      fcnt_q    <= '0;
      hall_q    <= '0;
      valid_q   <= 1'b0;
      jump_q    <= 1'b0;
      dir_q     <= 1'b0;
      scnt_q    <= '0;
      stopped_q <= 1'b1;
    end else begin
      hs_s1_q   <= hs_i;
      hs_s2_q   <= hs_s1_q;
      cand_q    <= cand_d;
      fcnt_q    <= fcnt_d;
      hall_q    <= hall_d;
      valid_q   <= valid_d;
      jump_q    <= jump_d;
      dir_q     <= dir_d;
      scnt_q    <= scnt_d;
      stopped_q <= stopped_d;
    end
  end

  assign hall_f_o     = hall_q;
  assign hall_valid_o = valid_q;
  assign hall_fault_o = jump_q ||
                        (valid_q && hall_idx(hall_q) == 3'd0);
  assign stopped_o    = stopped_q;
  assign motion_dir_o = dir_q;

endmodule

// File: rtl/bldc_mode_sequencer.sv
// Supervisory FSM that sequences the commutation UI bus:
// dead-time coast, regen brake before reversal, hall fault latch.
module bldc_mode_sequencer
  import bldc_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 16,
  parameter int unsigned STOP_CYCLES = 64,
  parameter int unsigned HALL_FILT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_cw,
  input  logic       cmd_ccw,
  input  logic       cmd_brake,
  input  logic [2:0] HS,
  output logic [2:0] UI,
  output logic       fault,
  output logic       stopped,
  output logic       motion_dir,
  output logic [2:0] state
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);

  logic [2:0]    cmd_s1_q, cmd_s2_q;
  state_e        state_q, state_d;
  logic          tgt_q, tgt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [2:0]    ui_q, ui_d;
  logic          fault_q, fault_d;

  logic [2:0] hall_f;
  logic       hall_valid, hall_fault, hall_ok;
  req_e       req;
  logic       req_dir, load;

  bldc_hall_monitor #(
    .STOP_CYCLES(STOP_CYCLES),
    .HALL_FILT  (HALL_FILT)
  ) u_hall (
    .clk         (clk),
    .rst_n       (rst_n),
    .hs_i        (HS),
    .hall_f_o    (hall_f),
    .hall_valid_o(hall_valid),
    .hall_fault_o(hall_fault),
    .stopped_o   (stopped),
    .motion_dir_o(motion_dir)
  );

  assign hall_ok = hall_valid && hall_idx(hall_f) != 3'd0;

  always_comb begin
    req = REQ_NONE;
    priority case (1'b1)
      cmd_s2_q[0]:               req = REQ_BRAKE;
      cmd_s2_q[2] ^ cmd_s2_q[1]: req = cmd_s2_q[2] ? REQ_CW
                                                   : REQ_CCW;
      default:                   req = REQ_NONE;
    endcase
  end

  assign req_dir = (req == REQ_CCW);

  // request evaluation shared by IDLE, BRAKE and re-targeting
  function automatic state_e eval_req(input req_e r,
                                      input logic stp,
                                      input logic mdir);
    case (r)
      REQ_BRAKE: return BRAKE;
      REQ_CW:    return (stp || !mdir) ? DEAD : REVBRAKE;
      REQ_CCW:   return (stp || mdir) ? DEAD : REVBRAKE;
      default:   return IDLE;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    dcnt_d  = dcnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, BRAKE: begin
        state_d = eval_req(req, stopped, motion_dir);
        load    = (req == REQ_CW) || (req == REQ_CCW);
      end
      REVBRAKE: begin
        if (req == REQ_NONE)
          state_d = IDLE;
        else if (req == REQ_BRAKE)
          state_d = BRAKE;
        else if (req_dir != tgt_q || stopped) begin
          state_d = eval_req(req, stopped, motion_dir);
          load    = 1'b1;
        end
      end
      DEAD: begin
        if (req == REQ_NONE)
          state_d = IDLE;
        else if (req == REQ_BRAKE)
          state_d = BRAKE;
        else if (req_dir != tgt_q) begin
          state_d = eval_req(req, stopped, motion_dir);
          load    = 1'b1;
        end else if (dcnt_q == DW'(DEAD_CYCLES - 1))
          state_d = RUN;
        else
          dcnt_d = dcnt_q + 1'b1;
      end
      RUN: begin
        if (req == REQ_NONE)
          state_d = IDLE;
        else if (req == REQ_BRAKE)
          state_d = BRAKE;
        else if (req_dir != tgt_q) begin
          state_d = REVBRAKE;
          load    = 1'b1;
        end
      end
      FAULT: begin
        if (req == REQ_NONE && hall_ok)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      tgt_d  = req_dir;
      dcnt_d = '0;
    end
    if (hall_fault)
      state_d = FAULT;
  end

  always_comb begin
    ui_d    = UI_OFF;
    fault_d = (state_d == FAULT);
    unique case (state_d)
      RUN:             ui_d = tgt_d ? UI_CCW : UI_CW;
      BRAKE, REVBRAKE: ui_d = UI_BRK;
      default:         ui_d = UI_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_s1_q <= '0;
      cmd_s2_q <= '0;
      state_q  <= IDLE;
      tgt_q    <= 1'b0;
      dcnt_q   <= '0;
      ui_q     <= UI_OFF;
      fault_q  <= 1'b0;
    end else begin
      cmd_s1_q <= {cmd_cw, cmd_ccw, cmd_brake};
      cmd_s2_q <= cmd_s1_q;
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      dcnt_q   <= dcnt_d;
      ui_q     <= ui_d;
      fault_q  <= fault_d;
    end
  end

  assign UI    = ui_q;
  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_bldc_mode_sequencer.sv
// Scoreboard bench for bldc_mode_sequencer.
// Expectations are queued with stimulus and popped at observation.
module tb_bldc_mode_sequencer;
  import bldc_pkg::*;

  localparam int DC = 4;
  localparam int SC = 8;
  localparam int HF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_cw = 1'b0;
  logic       cmd_ccw = 1'b0;
  logic       cmd_brake = 1'b0;
  logic [2:0] HS = 3'b100;
  logic [2:0] UI;
  logic       fault, stopped, motion_dir;
  logic [2:0] state;

  int total = 0;
  int bad = 0;
  int n;
  logic flt_seen;

  typedef struct {
    string      tag;
    logic [2:0] ui;
    logic [2:0] st;
    logic       flt;
    int         n;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  bldc_mode_sequencer #(
    .DEAD_CYCLES(DC),
    .STOP_CYCLES(SC),
    .HALL_FILT  (HF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_cw    (cmd_cw),
    .cmd_ccw   (cmd_ccw),
    .cmd_brake (cmd_brake),
    .HS        (HS),
    .UI        (UI),
    .fault     (fault),
    .stopped   (stopped),
    .motion_dir(motion_dir),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic wait_st(input logic [2:0] s, input int lim);
    for (int i = 0; i < lim && state !== s; i++) @(negedge clk);
  endtask

  task automatic hs_step(input logic [2:0] v);
    HS = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    HS = 3'b100;
    repeat (3) @(negedge clk);
    sb.push_back('{"reset", UI_OFF, IDLE, 1'b0, 2});
    e = sb.pop_front(); total++;
    n = {stopped, motion_dir};
    if ({UI, state, fault} !== {e.ui, e.st, e.flt} || n != e.n) begin
      bad++;
      $display("FAIL %s: ui=%b st=%0d flt=%b sd=%0d want ui=%b st=%0d flt=%b sd=%0d",
               e.tag, UI, state, fault, n, e.ui, e.st, e.flt, e.n);
    end
  endtask

  task automatic test_dead_time;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    cmd_cw = 1'b1;
    sb.push_back('{"dead_len", UI_OFF, DEAD, 1'b0, DC});
    sb.push_back('{"run_cw", UI_CW, RUN, 1'b0, 0});
    sb.push_back('{"no_fault", UI_OFF, IDLE, 1'b0, 0});
    flt_seen = 1'b0;
    for (int i = 0; i < 20 && state !== DEAD; i++) begin
      flt_seen |= fault;
      @(negedge clk);
    end
    n = 0;
    for (int i = 0; i < 20 && UI === UI_OFF; i++) begin
      flt_seen |= fault;
      n++;
      @(negedge clk);
    end
    e = sb.pop_front(); total++;
    if (n != e.n) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", e.tag, n, e.n);
    end
    e = sb.pop_front(); total++;
    if ({UI, state, fault} !== {e.ui, e.st, e.flt}) begin
      bad++;
      $display("FAIL %s: ui=%b st=%0d flt=%b want ui=%b st=%0d flt=%b",
               e.tag, UI, state, fault, e.ui, e.st, e.flt);
    end
    e = sb.pop_front(); total++;
    if (flt_seen !== e.flt) begin
      bad++;
      $display("FAIL %s: got %b want %b", e.tag, flt_seen, e.flt);
    end
  endtask

  task automatic test_reversal;
    hs_step(3'b101);
    hs_step(3'b001);
    hs_step(3'b011);
    repeat (2) @(negedge clk);
    sb.push_back('{"cw_motion", UI_CW, RUN, 1'b0, 0});
    e = sb.pop_front(); total++;
    n = {stopped, motion_dir};
    if ({UI, state, fault} !== {e.ui, e.st, e.flt} || n != e.n) begin
      bad++;
      $display("FAIL %s: ui=%b st=%0d sd=%0d want ui=%b st=%0d sd=%0d",
               e.tag, UI, state, n, e.ui, e.st, e.n);
    end
    cmd_cw = 1'b0;
    cmd_ccw = 1'b1;
    sb.push_back('{"revbrake", UI_BRK, REVBRAKE, 1'b0, 0});
    hs_step(3'b010);
    e = sb.pop_front(); total++;
    if ({UI, state, fault} !== {e.ui, e.st, e.flt}) begin
      bad++;
      $display("FAIL %s: ui=%b st=%0d flt=%b want ui=%b st=%0d flt=%b",
               e.tag, UI, state, fault, e.ui, e.st, e.flt);
    end
    hs_step(3'b110);
    sb.push_back('{"brake_len", UI_BRK, REVBRAKE, 1'b0, SC});
    sb.push_back('{"rev_dead", UI_OFF, DEAD, 1'b0, 1});
    sb.push_back('{"rev_dead_len", UI_OFF, DEAD, 1'b0, DC});
    sb.push_back('{"run_ccw", UI_CCW, RUN, 1'b0, 0});
    n = 0;
    for (int i = 0; i < 60 && UI === UI_BRK; i++) begin
      n++;
      @(negedge clk);
    end
    e = sb.pop_front(); total++;
    if (n < e.n) begin
      bad++;
      $display("FAIL %s: got %0d want >=%0d", e.tag, n, e.n);
    end
    e = sb.pop_front(); total++;
    if ({UI, state, fault} !== {e.ui, e.st, e.flt} || stopped !== 1'(e.n)) begin
      bad++;
      $display("FAIL %s: ui=%b st=%0d stp=%b want ui=%b st=%0d stp=%0d",
               e.tag, UI, state, stopped, e.ui, e.st, e.n);
    end
    n = 0;
    for (int i = 0; i < 20 && UI === UI_OFF; i++) begin
      n++;
      @(negedge clk);
    end
    e = sb.pop_front(); total++;
    if (n != e.n) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", e.tag, n, e.n);
    end
    e = sb.pop_front(); total++;
    if ({UI, state, fault} !== {e.ui, e.st, e.flt}) begin
      bad++;
      $display("FAIL %s: ui=%b st=%0d flt=%b want ui=%b st=%0d flt=%b",
               e.tag, UI, state, fault, e.ui, e.st, e.flt);
    end
  endtask

  task automatic test_fault_level;
    HS = 3'b111;
    sb.push_back('{"fault_enter", UI_OFF, FAULT, 1'b1, 0});
    sb.push_back('{"fault_hold_cmd", UI_OFF, FAULT, 1'b1, 0});
    sb.push_back('{"fault_hold_valid", UI_OFF, FAULT, 1'b1, 0});
    sb.push_back('{"fault_exit", UI_OFF, IDLE, 1'b0, 0});
    for (int i = 0; i < 20 && fault !== 1'b1; i++) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        cmd_ccw = 1'b0;
        cmd_cw = 1'b1;
        repeat (8) @(negedge clk);
      end
      if (k == 2) begin
        HS = 3'b010;
        repeat (8) @(negedge clk);
      end
      if (k == 3) begin
        cmd_cw = 1'b0;
        wait_st(IDLE, 20);
      end
      e = sb.pop_front(); total++;
      if ({UI, state, fault} !== {e.ui, e.st, e.flt}) begin
        bad++;
        $display("FAIL %s: ui=%b st=%0d flt=%b want ui=%b st=%0d flt=%b",
                 e.tag, UI, state, fault, e.ui, e.st, e.flt);
      end
    end
  endtask

  task automatic test_illegal_jump;
    rst_n = 1'b0;
    HS = 3'b100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    sb.push_back('{"jump_pre", UI_OFF, IDLE, 1'b0, 0});
    sb.push_back('{"jump_fault", UI_OFF, FAULT, 1'b1, 3 + HF});
    sb.push_back('{"jump_clear", UI_OFF, IDLE, 1'b0, 0});
    e = sb.pop_front(); total++;
    if ({UI, state, fault} !== {e.ui, e.st, e.flt}) begin
      bad++;
      $display("FAIL %s: ui=%b st=%0d flt=%b want ui=%b st=%0d flt=%b",
               e.tag, UI, state, fault, e.ui, e.st, e.flt);
    end
    HS = 3'b011;
    n = 0;
    for (int i = 0; i < 20 && fault !== 1'b1; i++) begin
      n++;
      @(negedge clk);
    end
    e = sb.pop_front(); total++;
    if ({UI, state, fault} !== {e.ui, e.st, e.flt} || n != e.n) begin
      bad++;
      $display("FAIL %s: ui=%b st=%0d flt=%b lat=%0d want ui=%b st=%0d flt=%b lat=%0d",
               e.tag, UI, state, fault, n, e.ui, e.st, e.flt, e.n);
    end
    @(negedge clk);
    e = sb.pop_front(); total++;
    if ({UI, state, fault} !== {e.ui, e.st, e.flt}) begin
      bad++;
      $display("FAIL %s: ui=%b st=%0d flt=%b want ui=%b st=%0d flt=%b",
               e.tag, UI, state, fault, e.ui, e.st, e.flt);
    end
  endtask

  task automatic test_both_dirs;
    cmd_cw = 1'b1;
    sb.push_back('{"both_run", UI_CW, RUN, 1'b0, 0});
    sb.push_back('{"both_idle", UI_OFF, IDLE, 1'b0, 0});
    sb.push_back('{"both_brake", UI_BRK, BRAKE, 1'b0, 0});
    for (int k = 0; k < 3; k++) begin
      if (k == 0) wait_st(RUN, 30);
      if (k == 1) begin
        cmd_ccw = 1'b1;
        wait_st(IDLE, 10);
      end
      if (k == 2) begin
        cmd_brake = 1'b1;
        wait_st(BRAKE, 10);
      end
      e = sb.pop_front(); total++;
      if ({UI, state, fault} !== {e.ui, e.st, e.flt}) begin
        bad++;
        $display("FAIL %s: ui=%b st=%0d flt=%b want ui=%b st=%0d flt=%b",
                 e.tag, UI, state, fault, e.ui, e.st, e.flt);
      end
    end
  endtask

  task automatic test_reset_in_revbrake;
    cmd_cw = 1'b0;
    cmd_ccw = 1'b0;
    hs_step(3'b001);
    hs_step(3'b101);
    cmd_brake = 1'b0;
    cmd_cw = 1'b1;
    sb.push_back('{"rb_enter", UI_BRK, REVBRAKE, 1'b0, 0});
    sb.push_back('{"rb_reset", UI_OFF, IDLE, 1'b0, 1});
    hs_step(3'b100);
    wait_st(REVBRAKE, 10);
    e = sb.pop_front(); total++;
    if ({UI, state, fault} !== {e.ui, e.st, e.flt}) begin
      bad++;
      $display("FAIL %s: ui=%b st=%0d flt=%b want ui=%b st=%0d flt=%b",
               e.tag, UI, state, fault, e.ui, e.st, e.flt);
    end
    rst_n = 1'b0;
    cmd_cw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    e = sb.pop_front(); total++;
    if ({UI, state, fault} !== {e.ui, e.st, e.flt} || stopped !== 1'(e.n)) begin
      bad++;
      $display("FAIL %s: ui=%b st=%0d flt=%b stp=%b want ui=%b st=%0d flt=%b stp=%0d",
               e.tag, UI, state, fault, stopped, e.ui, e.st, e.flt, e.n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_dead_time();
    test_reversal();
    test_fault_level();
    test_illegal_jump();
    test_both_dirs();
    test_reset_in_revbrake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
